// File: rtl/fifo_wr_arbiter_if.sv
// Bus bundle between the write requesters, the round-robin arbiter and the FIFO write port.
// The optional overflow counter is selected by FIFO_ARB_OVF_CNT_EN.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_BITS = 3,
    parameter int CNT_BITS  = 8
);
    // Handshake: req_tick[i] is a one-cycle request with no back-pressure; the
    // arbiter latches it into a pending slot or drops it. fifo_wr_en is a one-cycle
    // strobe that fires only after an IDLE cycle saw fifo_full low. grant is
    // one-hot while fifo_wr_en is high and zero at all other times.
    logic [NUM_REQ-1:0]           req_tick;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic                         fifo_full;
    logic                         fifo_wr_en;
    logic [DATA_BITS-1:0]         fifo_data_in;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           pending;
    logic [CNT_BITS-1:0]          ovf_cnt;
    logic [1:0]                   fsm_state;

    modport master (
        output req_tick, req_data, fifo_full,
        input  fifo_wr_en, fifo_data_in, grant, pending, ovf_cnt, fsm_state
    );

    modport slave (
        input  req_tick, req_data, fifo_full,
        output fifo_wr_en, fifo_data_in, grant, pending, ovf_cnt, fsm_state
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ tick sources.
// Define FIFO_ARB_OVF_CNT_EN to build the saturating dropped-tick counter.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_BITS = 3,
    parameter int CNT_BITS  = 8
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 fifo_wr_en_q, fifo_wr_en_d;
    logic [DATA_BITS-1:0] fifo_data_q, fifo_data_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_BITS-1:0] hold_q [NUM_REQ];
    logic [DATA_BITS-1:0] hold_d [NUM_REQ];

    logic [NUM_REQ-1:0]   clr;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand_idx;
    int                   cand;

    // First pending requester strictly after the last one served, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + 1 + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_found && pending_q[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        fifo_wr_en_d = 1'b0;
        fifo_data_d  = fifo_data_q;
        grant_d      = '0;
        winner_d     = winner_q;
        rr_ptr_d     = rr_ptr_q;
        clr          = '0;
        hold_d       = hold_q;

        case (state_q)
            IDLE: begin
                if (pick_found && !bus.fifo_full) begin
                    winner_d     = pick_idx;
                    fifo_data_d  = hold_q[pick_idx];
                    grant_d      = NUM_REQ'(1) << pick_idx;
                    fifo_wr_en_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                clr[winner_q] = 1'b1;
                rr_ptr_d      = winner_q;
                state_d       = SETTLE;
            end
            default: state_d = IDLE;
        endcase

        // A new tick on the slot being cleared re-arms it rather than being dropped.
        pending_d = pending_q & ~clr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_tick[i] && (!pending_q[i] || clr[i])) begin
                pending_d[i] = 1'b1;
                hold_d[i]    = bus.req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fifo_wr_en_q <= 1'b0;
            fifo_data_q  <= '0;
            grant_q      <= '0;
            pending_q    <= '0;
            winner_q     <= '0;
            rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
            for (int i = 0; i < NUM_REQ; i++) hold_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            fifo_wr_en_q <= fifo_wr_en_d;
            fifo_data_q  <= fifo_data_d;
            grant_q      <= grant_d;
            pending_q    <= pending_d;
            winner_q     <= winner_d;
            rr_ptr_q     <= rr_ptr_d;
            for (int i = 0; i < NUM_REQ; i++) hold_q[i] <= hold_d[i];
        end
    end

    assign bus.fifo_wr_en   = fifo_wr_en_q;
    assign bus.fifo_data_in = fifo_data_q;
    assign bus.grant        = grant_q;
    assign bus.pending      = pending_q;
    assign bus.fsm_state    = state_q;

`ifdef FIFO_ARB_OVF_CNT_EN
    localparam int SUM_W = CNT_BITS + 4;

    logic [CNT_BITS-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [SUM_W-1:0]    ovf_sum;

    // Extra headroom lets several drops in one cycle saturate cleanly.
    always_comb begin
        ovf_sum = SUM_W'(ovf_cnt_q);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_tick[i] && pending_q[i] && !clr[i]) ovf_sum = ovf_sum + SUM_W'(1);
        end
        if (ovf_sum > SUM_W'({CNT_BITS{1'b1}})) ovf_cnt_d = '1;
        else                                    ovf_cnt_d = ovf_sum[CNT_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_cnt_q <= '0;
        else     ovf_cnt_q <= ovf_cnt_d;
    end

    assign bus.ovf_cnt = ovf_cnt_q;
`else
    assign bus.ovf_cnt = {CNT_BITS{1'b0}};
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected writes are queued at stimulus time and
// matched by an independent write monitor (grant, data and cycle of each strobe).
module tb_fifo_wr_arbiter;
    localparam int NR = 2;
    localparam int DB = 3;
    localparam int CB = 8;
    localparam int W  = 16 + NR + DB;
`ifdef FIFO_ARB_OVF_CNT_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_q[$];

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB), .CNT_BITS(CB)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .CNT_BITS(CB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic do_reset();
        rst           = 1'b1;
        bus.req_tick  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tick(input logic [NR-1:0] t, input logic [NR*DB-1:0] d);
        bus.req_tick = t;
        bus.req_data = d;
        @(negedge clk);
        bus.req_tick = '0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input logic [NR-1:0] g, input logic [DB-1:0] d);
        exp_q.push_back({16'(c), g, d});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DB-1:0] fdat(input int n);
        return DB'((n * 3 + 1) % 8);
    endfunction

    // scoreboard monitor
    logic [W-1:0] exp_e;
    logic [W-1:0] got_e;
    always @(negedge clk) begin
        if (bus.fifo_wr_en) begin
            checks++;
            got_e = {16'(cyc), bus.grant, bus.fifo_data_in};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: cycle %0d grant %b data %b, none expected",
                         cyc, bus.grant, bus.fifo_data_in);
            end else begin
                exp_e = exp_q.pop_front();
                if (got_e !== exp_e) begin
                    errors++;
                    $display("FAIL write: got cycle %0d grant %b data %b expected cycle %0d grant %b data %b",
                             got_e[W-1:NR+DB], got_e[NR+DB-1:DB], got_e[DB-1:0],
                             exp_e[W-1:NR+DB], exp_e[NR+DB-1:DB], exp_e[DB-1:0]);
                end
            end
        end else if (bus.grant != '0) begin
            checks++;
            errors++;
            $display("FAIL grant_idle: got grant %b expected 00 with no write", bus.grant);
        end
    end

    initial begin
        int k;
        int m;
        bus.req_tick  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        // reset values
        do_reset();
        check("rst_wr_en",   32'(bus.fifo_wr_en),   32'd0);
        check("rst_data",    32'(bus.fifo_data_in), 32'd0);
        check("rst_grant",   32'(bus.grant),        32'd0);
        check("rst_pending", 32'(bus.pending),      32'd0);
        check("rst_ovf",     32'(bus.ovf_cnt),      32'd0);
        check("rst_state",   32'(bus.fsm_state),    32'd0);

        // single tick on requester 0
        k = cyc;
        push_exp(k + 2, 2'b01, 3'b101);
        tick(2'b01, {3'b000, 3'b101});
        check("single_pend_set", 32'(bus.pending), 32'b01);
        wait_to(k + 3);
        check("single_pend_clr", 32'(bus.pending), 32'b00);

        // simultaneous ticks after reset
        do_reset();
        k = cyc;
        push_exp(k + 2, 2'b01, 3'b001);
        push_exp(k + 5, 2'b10, 3'b110);
        tick(2'b11, {3'b110, 3'b001});
        check("simul_pend", 32'(bus.pending), 32'b11);
        wait_to(k + 7);
        check("simul_pend_clr", 32'(bus.pending), 32'b00);

        // round-robin fairness: each served requester re-ticks in its SETTLE cycle
        do_reset();
        k = cyc;
        for (int n = 0; n < 8; n++)
            push_exp(k + 2 + 3 * n, (n % 2 == 0) ? 2'b01 : 2'b10, fdat(n));
        tick(2'b11, {fdat(1), fdat(0)});
        for (int n = 0; n < 6; n++) begin
            wait_to(k + 3 + 3 * n);
            if (n % 2 == 0) tick(2'b01, {3'b000, fdat(n + 2)});
            else            tick(2'b10, {fdat(n + 2), 3'b000});
        end
        wait_to(k + 26);
        check("rr_pend_clr", 32'(bus.pending), 32'b00);

        // tick on the winner during ISSUE re-arms the slot with new data
        do_reset();
        k = cyc;
        push_exp(k + 2, 2'b01, 3'b010);
        push_exp(k + 5, 2'b01, 3'b111);
        tick(2'b01, {3'b000, 3'b010});
        wait_to(k + 2);
        tick(2'b01, {3'b000, 3'b111});
        check("issue_tick_pend", 32'(bus.pending), 32'b01);
        wait_to(k + 6);
        check("issue_tick_clr", 32'(bus.pending), 32'b00);
        check("issue_tick_ovf", 32'(bus.ovf_cnt), 32'd0);

        // full FIFO holds the request until full drops
        do_reset();
        bus.fifo_full = 1'b1;
        k = cyc;
        tick(2'b10, {3'b011, 3'b000});
        check("full_pend_a", 32'(bus.pending), 32'b10);
        wait_to(k + 5);
        check("full_pend_b", 32'(bus.pending), 32'b10);
        m = cyc;
        bus.fifo_full = 1'b0;
        push_exp(m + 1, 2'b10, 3'b011);
        wait_to(m + 4);
        check("full_pend_clr", 32'(bus.pending), 32'b00);

        // drops while full: older data kept, counter counts every drop
        do_reset();
        bus.fifo_full = 1'b1;
        k = cyc;
        tick(2'b01, {3'b000, 3'b001});
        tick(2'b01, {3'b000, 3'b010});
        tick(2'b01, {3'b000, 3'b100});
        check("ovf_three", 32'(bus.ovf_cnt), OVF_ON ? 32'd2 : 32'd0);
        tick(2'b10, {3'b101, 3'b000});
        check("ovf_pend_both", 32'(bus.pending), 32'b11);
        tick(2'b11, {3'b111, 3'b111});
        check("ovf_double", 32'(bus.ovf_cnt), OVF_ON ? 32'd4 : 32'd0);
        m = cyc;
        bus.fifo_full = 1'b0;
        push_exp(m + 1, 2'b01, 3'b001);
        push_exp(m + 4, 2'b10, 3'b101);
        wait_to(m + 6);
        check("ovf_hold", 32'(bus.ovf_cnt), OVF_ON ? 32'd4 : 32'd0);

        // reset in the cycle IDLE commits to a write
        k = cyc;
        tick(2'b01, {3'b000, 3'b110});
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_en",   32'(bus.fifo_wr_en), 32'd0);
        check("mid_rst_pending", 32'(bus.pending),    32'd0);
        check("mid_rst_grant",   32'(bus.grant),      32'd0);
        check("mid_rst_ovf",     32'(bus.ovf_cnt),    32'd0);
        check("mid_rst_state",   32'(bus.fsm_state),  32'd0);
        rst = 1'b0;
        wait_to(k + 8);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
